// File: rtl/pc_sequencer_if.sv
// Decode-to-sequencer bus: instruction/flag inputs in, pc load command out.
interface pc_sequencer_if #(
    parameter int unsigned AW = 8
);
    logic          instr_valid;
    logic [3:0]    op;
    logic [AW-1:0] target;
    logic [AW-1:0] pc;
    logic          flag_z;
    logic          flag_n;
    logic          flag_c;
    logic          resume;
    logic          pc_load;
    logic [AW-1:0] pc_k8;

    modport master (
        output instr_valid, op, target, pc, flag_z, flag_n, flag_c, resume,
        input  pc_load, pc_k8
    );

    modport slave (
        input  instr_valid, op, target, pc, flag_z, flag_n, flag_c, resume,
        output pc_load, pc_k8
    );
endinterface

// File: rtl/pc_sequencer.sv
// Control-flow sequencer: decides pc load/target each cycle, with a hardware return stack,
// stall, HALT/resume and a sticky stack-fault state.
module pc_sequencer #(
    parameter int unsigned          AW        = 8,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [AW-1:0]        RESET_VEC = 8'h00,
    parameter logic [AW-1:0]        FAULT_VEC = 8'hFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pc_sequencer_if.slave             bus,
    output logic                      flush,
    output logic                      halted,
    output logic                      stack_err,
    output logic [$clog2(DEPTH):0]    sp_depth
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW:0] SpFull = (IW + 1)'(DEPTH);

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StHalted = 2'd1;
    localparam logic [1:0] StFault  = 2'd2;

    localparam logic [3:0] OpJmp  = 4'd1;
    localparam logic [3:0] OpJeq  = 4'd2;
    localparam logic [3:0] OpJne  = 4'd3;
    localparam logic [3:0] OpJgt  = 4'd4;
    localparam logic [3:0] OpJlt  = 4'd5;
    localparam logic [3:0] OpJge  = 4'd6;
    localparam logic [3:0] OpJle  = 4'd7;
    localparam logic [3:0] OpJcr  = 4'd8;
    localparam logic [3:0] OpCall = 4'd9;
    localparam logic [3:0] OpRet  = 4'd10;
    localparam logic [3:0] OpHalt = 4'd11;

    logic [1:0]    state_q, state_d;
    logic [IW:0]   sp_q;
    logic [AW-1:0] stack_q [DEPTH];
    logic [IW-1:0] top_idx;
    logic [AW-1:0] ret_addr;
    logic          push, pop, taken, cond;

    assign top_idx  = IW'(sp_q - 1'b1);
    assign ret_addr = bus.pc + AW'(1);
    assign sp_depth = sp_q;

    always_comb begin
        cond = 1'b0;
        unique case (bus.op)
            OpJmp:   cond = 1'b1;
            OpJeq:   cond = bus.flag_z;
            OpJne:   cond = !bus.flag_z;
            OpJgt:   cond = !bus.flag_z && !bus.flag_n;
            OpJlt:   cond = bus.flag_n;
            OpJge:   cond = !bus.flag_n;
            OpJle:   cond = bus.flag_z || bus.flag_n;
            OpJcr:   cond = bus.flag_c;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        bus.pc_load = 1'b0;
        bus.pc_k8   = bus.pc;
        push        = 1'b0;
        pop         = 1'b0;
        taken       = 1'b0;
        state_d     = state_q;
        // Reset drives the vector combinationally so pc is forced while rst_n is low.
        if (!rst_n) begin
            bus.pc_load = 1'b1;
            bus.pc_k8   = RESET_VEC;
        end else begin
            case (state_q)
                StRun: begin
                    if (!bus.instr_valid) begin
                        bus.pc_load = 1'b1;
                    end else if (bus.op == OpCall) begin
                        bus.pc_load = 1'b1;
                        if (sp_q == SpFull) begin
                            bus.pc_k8 = FAULT_VEC;
                            state_d   = StFault;
                        end else begin
                            bus.pc_k8 = bus.target;
                            push      = 1'b1;
                            taken     = 1'b1;
                        end
                    end else if (bus.op == OpRet) begin
                        bus.pc_load = 1'b1;
                        if (sp_q == '0) begin
                            bus.pc_k8 = FAULT_VEC;
                            state_d   = StFault;
                        end else begin
                            bus.pc_k8 = stack_q[top_idx];
                            pop       = 1'b1;
                            taken     = 1'b1;
                        end
                    end else if (bus.op == OpHalt) begin
                        bus.pc_load = 1'b1;
                        state_d     = StHalted;
                    end else if (cond) begin
                        bus.pc_load = 1'b1;
                        bus.pc_k8   = bus.target;
                        taken       = 1'b1;
                    end
                end
                StHalted: begin
                    // Leaving HALTED lets pc step past the HALT instruction.
                    if (bus.resume) begin
                        state_d = StRun;
                    end else begin
                        bus.pc_load = 1'b1;
                    end
                end
                default: begin
                    bus.pc_load = 1'b1;
                    bus.pc_k8   = FAULT_VEC;
                    state_d     = StFault;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            sp_q      <= '0;
            flush     <= 1'b0;
            halted    <= 1'b0;
            stack_err <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            flush     <= taken;
            halted    <= (state_d == StHalted);
            stack_err <= (state_d == StFault);
            if (push) begin
                stack_q[sp_q[IW-1:0]] <= ret_addr;
                sp_q                  <= sp_q + 1'b1;
            end else if (pop) begin
                sp_q <= sp_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expectations, a negedge monitor checks.
module tb_pc_sequencer;
    localparam logic [3:0] NOP = 4'd0, JMP = 4'd1, JEQ = 4'd2, JNE = 4'd3, JGT = 4'd4,
                           JLT = 4'd5, JGE = 4'd6, JLE = 4'd7, JCR = 4'd8, CALL = 4'd9,
                           RET = 4'd10, HALT = 4'd11, OP12 = 4'd12;

    typedef struct {
        string      nm;
        bit         ld;
        logic [7:0] k8;
        bit         fl;
        bit         ha;
        bit         er;
        logic [2:0] sp;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       flush, halted, stack_err;
    logic [2:0] sp_depth;
    int         n_vec;
    int         n_bad;
    exp_t       q[$];
    exp_t       e;

    pc_sequencer_if #(.AW(8)) bus ();

    pc_sequencer #(
        .AW       (8),
        .DEPTH    (4),
        .RESET_VEC(8'h00),
        .FAULT_VEC(8'hFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flush    (flush),
        .halted   (halted),
        .stack_err(stack_err),
        .sp_depth (sp_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered expectations are the values visible during the cycle the vector is applied.
    task automatic vec(input string nm, input bit r, input bit v, input logic [3:0] o,
                       input logic [7:0] tg, input logic [7:0] p, input logic [2:0] f,
                       input bit rs, input bit el, input logic [7:0] ek, input bit ef,
                       input bit eh, input bit ee, input logic [2:0] esp);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n           = r;
        bus.instr_valid = v;
        bus.op          = o;
        bus.target      = tg;
        bus.pc          = p;
        bus.flag_z      = f[2];
        bus.flag_n      = f[1];
        bus.flag_c      = f[0];
        bus.resume      = rs;
        x.nm = nm; x.ld = el; x.k8 = ek; x.fl = ef; x.ha = eh; x.er = ee; x.sp = esp;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (bus.pc_load !== e.ld || (e.ld && bus.pc_k8 !== e.k8) || flush !== e.fl ||
                halted !== e.ha || stack_err !== e.er || sp_depth !== e.sp) begin
                n_bad++;
                $display("FAIL %s: got load=%b k8=%h flush=%b halted=%b err=%b sp=%0d, want load=%b k8=%h flush=%b halted=%b err=%b sp=%0d",
                         e.nm, bus.pc_load, bus.pc_k8, flush, halted, stack_err, sp_depth,
                         e.ld, e.k8, e.fl, e.ha, e.er, e.sp);
            end
        end
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.instr_valid = 1'b0; bus.op = NOP; bus.target = '0; bus.pc = '0;
        bus.flag_z = 1'b0; bus.flag_n = 1'b0; bus.flag_c = 1'b0; bus.resume = 1'b0;

        // T1 reset and plain NOPs
        vec("rst0", 0, 1, JMP, 8'h40, 8'h00, 3'b000, 0, 1, 8'h00, 0, 0, 0, 0);
        vec("rst1", 0, 1, JMP, 8'h40, 8'h00, 3'b000, 0, 1, 8'h00, 0, 0, 0, 0);
        vec("nop0", 1, 1, NOP, 8'h40, 8'h00, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);
        vec("nop1", 1, 1, NOP, 8'h40, 8'h01, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);
        vec("nop2", 1, 1, NOP, 8'h40, 8'h02, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);

        // T2 conditional branches, flags {z,n,c}
        vec("jeq_t", 1, 1, JEQ, 8'h40, 8'h03, 3'b100, 0, 1, 8'h40, 0, 0, 0, 0);
        vec("jeq_u", 1, 1, JEQ, 8'h40, 8'h03, 3'b000, 0, 0, 8'h00, 1, 0, 0, 0);
        vec("jne_t", 1, 1, JNE, 8'h40, 8'h03, 3'b000, 0, 1, 8'h40, 0, 0, 0, 0);
        vec("jne_u", 1, 1, JNE, 8'h40, 8'h03, 3'b100, 0, 0, 8'h00, 1, 0, 0, 0);
        vec("jgt_t", 1, 1, JGT, 8'h40, 8'h03, 3'b001, 0, 1, 8'h40, 0, 0, 0, 0);
        vec("jgt_un", 1, 1, JGT, 8'h40, 8'h03, 3'b010, 0, 0, 8'h00, 1, 0, 0, 0);
        vec("jgt_uz", 1, 1, JGT, 8'h40, 8'h03, 3'b100, 0, 0, 8'h00, 0, 0, 0, 0);
        vec("jlt_t", 1, 1, JLT, 8'h40, 8'h03, 3'b010, 0, 1, 8'h40, 0, 0, 0, 0);
        vec("jlt_u", 1, 1, JLT, 8'h40, 8'h03, 3'b100, 0, 0, 8'h00, 1, 0, 0, 0);
        vec("jge_t", 1, 1, JGE, 8'h40, 8'h03, 3'b100, 0, 1, 8'h40, 0, 0, 0, 0);
        vec("jge_u", 1, 1, JGE, 8'h40, 8'h03, 3'b010, 0, 0, 8'h00, 1, 0, 0, 0);
        vec("jle_tz", 1, 1, JLE, 8'h40, 8'h03, 3'b100, 0, 1, 8'h40, 0, 0, 0, 0);
        vec("jle_tn", 1, 1, JLE, 8'h40, 8'h03, 3'b010, 0, 1, 8'h40, 1, 0, 0, 0);
        vec("jle_u", 1, 1, JLE, 8'h40, 8'h03, 3'b001, 0, 0, 8'h00, 1, 0, 0, 0);
        vec("jcr_t", 1, 1, JCR, 8'h40, 8'h03, 3'b001, 0, 1, 8'h40, 0, 0, 0, 0);
        vec("jcr_u", 1, 1, JCR, 8'h40, 8'h03, 3'b110, 0, 0, 8'h00, 1, 0, 0, 0);
        vec("jmp", 1, 1, JMP, 8'h40, 8'h03, 3'b000, 0, 1, 8'h40, 0, 0, 0, 0);
        vec("nop_fl", 1, 1, NOP, 8'h40, 8'h40, 3'b111, 0, 0, 8'h00, 1, 0, 0, 0);
        vec("op12", 1, 1, OP12, 8'h40, 8'h41, 3'b111, 0, 0, 8'h00, 0, 0, 0, 0);

        // T3 nested CALL/RET
        vec("call1", 1, 1, CALL, 8'h20, 8'h10, 3'b000, 0, 1, 8'h20, 0, 0, 0, 0);
        vec("call2", 1, 1, CALL, 8'h30, 8'h20, 3'b000, 0, 1, 8'h30, 1, 0, 0, 1);
        vec("ret1", 1, 1, RET, 8'h00, 8'h30, 3'b000, 0, 1, 8'h21, 1, 0, 0, 2);
        vec("ret2", 1, 1, RET, 8'h00, 8'h21, 3'b000, 0, 1, 8'h11, 1, 0, 0, 1);
        vec("t3_nop", 1, 1, NOP, 8'h00, 8'h11, 3'b000, 0, 0, 8'h00, 1, 0, 0, 0);
        vec("t3_nop2", 1, 1, NOP, 8'h00, 8'h12, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);

        // T6 stall, HALT, resume
        vec("stall", 1, 0, JMP, 8'h40, 8'h05, 3'b000, 0, 1, 8'h05, 0, 0, 0, 0);
        vec("post_stall", 1, 1, NOP, 8'h40, 8'h05, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);
        vec("halt", 1, 1, HALT, 8'h40, 8'h07, 3'b000, 0, 1, 8'h07, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            vec("halted", 1, 1, JMP, 8'h40, 8'h07, 3'b000, 0, 1, 8'h07, 0, 1, 0, 0);
        end
        vec("resume", 1, 1, JMP, 8'h40, 8'h07, 3'b000, 1, 0, 8'h00, 0, 1, 0, 0);
        vec("post_res", 1, 1, NOP, 8'h40, 8'h08, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);

        // Return-address wrap
        vec("call_ff", 1, 1, CALL, 8'h50, 8'hFF, 3'b000, 0, 1, 8'h50, 0, 0, 0, 0);
        vec("ret_wrap", 1, 1, RET, 8'h00, 8'h50, 3'b000, 0, 1, 8'h00, 1, 0, 0, 1);
        vec("wrap_nop", 1, 1, NOP, 8'h00, 8'h00, 3'b000, 0, 0, 8'h00, 1, 0, 0, 0);

        // Reset during CALL leaves no partial push
        vec("rst_call", 0, 1, CALL, 8'h44, 8'h33, 3'b000, 0, 1, 8'h00, 0, 0, 0, 0);
        vec("rst_rel", 1, 1, NOP, 8'h00, 8'h00, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);

        // T5 underflow -> FAULT, held until reset
        vec("ret_uf", 1, 1, RET, 8'h00, 8'h09, 3'b000, 0, 1, 8'hFF, 0, 0, 0, 0);
        vec("fault0", 1, 1, NOP, 8'h00, 8'h0A, 3'b000, 0, 1, 8'hFF, 0, 0, 1, 0);
        vec("fault1", 1, 1, JMP, 8'h40, 8'h0B, 3'b000, 1, 1, 8'hFF, 0, 0, 1, 0);
        vec("rst_f", 0, 1, NOP, 8'h00, 8'h00, 3'b000, 0, 1, 8'h00, 0, 0, 0, 0);
        vec("rel_f", 1, 1, NOP, 8'h00, 8'h00, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);

        // T4 overflow on fifth CALL
        vec("ov_c1", 1, 1, CALL, 8'h10, 8'h01, 3'b000, 0, 1, 8'h10, 0, 0, 0, 0);
        vec("ov_c2", 1, 1, CALL, 8'h20, 8'h10, 3'b000, 0, 1, 8'h20, 1, 0, 0, 1);
        vec("ov_c3", 1, 1, CALL, 8'h30, 8'h20, 3'b000, 0, 1, 8'h30, 1, 0, 0, 2);
        vec("ov_c4", 1, 1, CALL, 8'h40, 8'h30, 3'b000, 0, 1, 8'h40, 1, 0, 0, 3);
        vec("ov_c5", 1, 1, CALL, 8'h50, 8'h40, 3'b000, 0, 1, 8'hFF, 1, 0, 0, 4);
        vec("ov_f0", 1, 1, NOP, 8'h00, 8'h50, 3'b000, 1, 1, 8'hFF, 0, 0, 1, 4);
        vec("ov_f1", 1, 1, RET, 8'h00, 8'h51, 3'b000, 0, 1, 8'hFF, 0, 0, 1, 4);
        vec("ov_rst", 0, 1, NOP, 8'h00, 8'h00, 3'b000, 0, 1, 8'h00, 0, 0, 0, 0);
        vec("ov_rel", 1, 1, NOP, 8'h00, 8'h00, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending vectors, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
